// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a circular return-address stack.
// Each rising clk edge applies reset, then stall, then the requested mode
// (SEQ / JUMP / CALL / RET). A CALL on a full stack overwrites the oldest
// entry. A RET on an empty stack falls through as SEQ. Both events raise
// sticky flags that only reset clears.
module pc_sequencer #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int              STEP       = 4,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic [1:0]                       mode,
  input  logic [WIDTH-1:0]                 target,
  output logic [WIDTH-1:0]                 pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_full,
  output logic                             ras_empty,
  output logic                             ras_ovf,
  output logic                             ras_unf
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [1:0] MODE_SEQ  = 2'b00;
  localparam logic [1:0] MODE_JUMP = 2'b01;
  localparam logic [1:0] MODE_CALL = 2'b10;
  localparam logic [1:0] MODE_RET  = 2'b11;

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);

  // Registered state. top_r always points at the slot the next CALL writes,
  // so the newest entry sits one slot below it (circularly).
  logic [WIDTH-1:0] pc_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] top_r;
  logic             ovf_r;
  logic             unf_r;
  logic [WIDTH-1:0] stack_r [RAS_DEPTH];

  // Next-state values
  logic [WIDTH-1:0] pc_s;
  logic [CNT_W-1:0] count_s;
  logic [PTR_W-1:0] top_s;
  logic             ovf_s;
  logic             unf_s;
  logic             push_s;
  logic [WIDTH-1:0] seq_pc_s;
  logic [PTR_W-1:0] top_inc_s;
  logic [PTR_W-1:0] top_dec_s;

  // Circular pointer neighbours and the sequential address (silent wrap).
  always_comb begin
    seq_pc_s  = pc_r + STEP_W;
    if (top_r == PTR_LAST) begin
      top_inc_s = '0;
    end else begin
      top_inc_s = top_r + PTR_W'(1);
    end
    if (top_r == '0) begin
      top_dec_s = PTR_LAST;
    end else begin
      top_dec_s = top_r - PTR_W'(1);
    end
  end

  // Next-state decode. Stall keeps every default, which holds all state.
  always_comb begin
    pc_s    = pc_r;
    count_s = count_r;
    top_s   = top_r;
    ovf_s   = ovf_r;
    unf_s   = unf_r;
    push_s  = 1'b0;
    if (stall) begin
      pc_s = pc_r;
    end else begin
      case (mode)
        MODE_SEQ: begin
          pc_s = seq_pc_s;
        end
        MODE_JUMP: begin
          pc_s = target;
        end
        MODE_CALL: begin
          // A push on a full stack lands on the oldest slot.
          push_s = 1'b1;
          pc_s   = target;
          top_s  = top_inc_s;
          if (count_r == CNT_FULL) begin
            ovf_s = 1'b1;
          end else begin
            count_s = count_r + CNT_W'(1);
          end
        end
        MODE_RET: begin
          if (count_r == '0) begin
            pc_s  = seq_pc_s;
            unf_s = 1'b1;
          end else begin
            pc_s    = stack_r[top_dec_s];
            top_s   = top_dec_s;
            count_s = count_r - CNT_W'(1);
          end
        end
        default: begin
          pc_s = pc_r;
        end
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r    <= RESET_ADDR;
      count_r <= '0;
      top_r   <= '0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      pc_r    <= pc_s;
      count_r <= count_s;
      top_r   <= top_s;
      ovf_r   <= ovf_s;
      unf_r   <= unf_s;
    end
  end

  // Stack storage. Contents are not cleared on reset; count_r hides stale data.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      stack_r[top_r] <= seq_pc_s;
    end
  end

  assign pc        = pc_r;
  assign ras_count = count_r;
  assign ras_full  = (count_r == CNT_FULL);
  assign ras_empty = (count_r == '0);
  assign ras_ovf   = ovf_r;
  assign ras_unf   = unf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (default parameters).
// The driver applies one operation per cycle and pushes the state the
// reference model predicts. The monitor pops one prediction after each
// rising edge and compares it with the DUT outputs.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  mode;
  logic [31:0] target;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .mode(mode), .target(target),
    .pc(pc), .ras_count(ras_count), .ras_full(ras_full),
    .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          cnt;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the stack is a queue, with the newest entry at the back.
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_stk[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  function automatic void model_step(bit rst, bit stl, logic [1:0] md, logic [31:0] tgt);
    if (rst) begin
      m_pc = 32'd0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!stl) begin
      case (md)
        2'd0: m_pc = m_pc + 32'd4;
        2'd1: m_pc = tgt;
        2'd2: begin
          if (m_stk.size() == 4) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
          end
          m_stk.push_back(m_pc + 32'd4);
          m_pc = tgt;
        end
        default: begin
          if (m_stk.size() == 0) begin
            m_pc  = m_pc + 32'd4;
            m_unf = 1'b1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
      endcase
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one operation before the next rising edge and record the prediction.
  task automatic op(bit rst, bit stl, logic [1:0] md, logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    stall  = stl;
    mode   = md;
    target = tgt;
    model_step(rst, stl, md, tgt);
    e.pc  = m_pc;
    e.cnt = m_stk.size();
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  // Monitor: one prediction per rising edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",        pc,                 e.pc);
        chk("ras_count", {29'd0, ras_count}, e.cnt);
        chk("ras_full",  {31'd0, ras_full},  {31'd0, e.cnt == 4});
        chk("ras_empty", {31'd0, ras_empty}, {31'd0, e.cnt == 0});
        chk("ras_ovf",   {31'd0, ras_ovf},   {31'd0, e.ovf});
        chk("ras_unf",   {31'd0, ras_unf},   {31'd0, e.unf});
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b1; stall = 1'b0; mode = 2'd0; target = 32'd0;

    // Reset, then three SEQ steps: 0, 4, 8, 12
    op(1, 0, 2'd0, 32'd0);
    for (int i = 0; i < 3; i++) op(0, 0, 2'd0, $urandom);

    // Nested call and return from pc=100
    op(0, 0, 2'd1, 32'd100);
    op(0, 0, 2'd2, 32'd200);
    op(0, 0, 2'd2, 32'd300);
    op(0, 0, 2'd3, $urandom);
    op(0, 0, 2'd3, $urandom);

    // Overflow with five calls from pc=0, then six returns (the last two underflow)
    op(1, 0, 2'd0, 32'd0);
    for (int i = 1; i <= 5; i++) op(0, 0, 2'd2, 32'(i * 16));
    for (int i = 0; i < 6; i++) op(0, 0, 2'd3, 32'd0);
    // Sticky flags survive legal operations
    op(0, 0, 2'd2, 32'd40);
    op(0, 0, 2'd3, 32'd0);

    // Silent wrap, then an unaligned jump
    op(1, 0, 2'd0, 32'd0);
    op(0, 0, 2'd1, 32'hFFFF_FFFC);
    op(0, 0, 2'd0, 32'd0);
    op(0, 0, 2'd1, 32'h0000_0123);

    // Stall holds a pending CALL until released
    op(0, 1, 2'd2, 32'd500);
    op(0, 1, 2'd2, 32'd500);
    op(0, 0, 2'd2, 32'd500);

    // Reset wins over a coincident CALL at ras_count=2
    op(0, 0, 2'd2, 32'd600);
    op(1, 0, 2'd2, 32'd700);
    op(0, 0, 2'd0, 32'd0);

    // Random traffic with occasional reset and stall
    for (int i = 0; i < 400; i++) begin
      op(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0),
         2'($urandom_range(0, 3)), $urandom);
    end
    op(0, 1, 2'd0, 32'd0);

    // Drain the scoreboard within a bounded number of cycles
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC and target width in bits.
REQ-002 SHALL have parameter RESET_ADDR, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter STEP, default 4: sequential increment.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries, minimum 1.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port stall  input  1  hold all state this cycle.
REQ-008 SHALL have port mode  input  2  00 SEQ, 01 JUMP, 10 CALL, 11 RET.
REQ-009 SHALL have port target  input  WIDTH  destination for JUMP/CALL.
REQ-010 SHALL have port pc  output  WIDTH  current program counter, registered.
REQ-011 SHALL have port ras_count  output  clog2(RAS_DEPTH+1)  valid stack entries.
REQ-012 SHALL have port ras_full  output  1  ras_count == RAS_DEPTH.
REQ-013 SHALL have port ras_empty  output  1  ras_count == 0.
REQ-014 SHALL have port ras_ovf  output  1  sticky: a CALL was issued while full.
REQ-015 SHALL have port ras_unf  output  1  sticky: a RET was issued while empty.

Function
REQ-016 SHALL apply priority reset > stall > mode at every rising clk edge.
REQ-017 SHALL, with stall=1 and reset=0, hold pc, stack contents, ras_count and sticky flags unchanged.
REQ-018 SHALL, in SEQ, load pc <= (pc + STEP) mod 2^WIDTH; wrap-around is silent, with no flag.
REQ-019 SHALL, in JUMP, load pc <= target unmodified, with no alignment masking; stack untouched.
REQ-020 SHALL, in CALL, push (pc + STEP) mod 2^WIDTH and load pc <= target in the same edge.
REQ-021 SHALL, on CALL with stack not full, increment ras_count by 1.
REQ-022 SHALL, on CALL with stack full, overwrite the oldest entry (circular), keep ras_count = RAS_DEPTH, and set ras_ovf.
REQ-023 SHALL, in RET with stack not empty, load pc <= top entry (LIFO) and decrement ras_count by 1.
REQ-024 SHALL, in RET with stack empty, behave as SEQ (pc <= pc + STEP), keep ras_count = 0, and set ras_unf.
REQ-025 SHALL, after an overflow, return the DEPTH most recent addresses in LIFO order on successive RETs; the discarded oldest is lost.
REQ-026 SHALL keep ras_ovf/ras_unf set until reset; they are not cleared by later legal operations.
REQ-027 SHALL derive ras_full, ras_empty and ras_count combinationally from registered state; no extra latency.
REQ-028 SHALL have one-cycle latency: the effect of mode/target sampled at edge N is visible on pc after edge N.
REQ-029 SHALL ignore target in SEQ and RET modes.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, set pc=RESET_ADDR, ras_count=0, ras_ovf=0, ras_unf=0, regardless of stall/mode.
REQ-031 SHALL abandon any in-flight CALL/RET sampled with reset=1; stack entry contents need not be cleared.
REQ-032 SHALL NOT let reset affect outputs between clock edges (synchronous only).

Verification
REQ-033 SHALL verify: reset 1 cycle, then SEQ x3 (defaults) -> pc 0, 4, 8, 12; ras_empty=1 throughout.
REQ-034 SHALL verify: pc=100, CALL target=200; CALL target=300; RET; RET -> pc 200, 300, 204, 104; ras_count 1, 2, 1, 0.
REQ-035 SHALL verify: 5 CALLs (RAS_DEPTH=4) from pc=0 to targets 16, 32, 48, 64, 80 -> ras_ovf=1 and ras_full=1; then 5 RETs -> pc 68, 52, 36, 20, then 24 with ras_unf=1.
REQ-036 SHALL verify: pc=0xFFFFFFFC, SEQ -> pc=0x00000000, no flag; JUMP target=0x123 -> pc=0x123.
REQ-037 SHALL verify: stall=1 with mode=CALL target=500 for 2 cycles -> pc and ras_count unchanged; stall=0 -> pc=500, ras_count=1.
REQ-038 SHALL verify: reset asserted coincident with CALL at ras_count=2 -> pc=RESET_ADDR, ras_count=0, flags 0.
